stream_mux_rr: RTL and testbench

- Parametrised N-to-1 streaming multiplexer; successor to the combinational 2:1 mux.
- Adds valid/ready handshaking on every input and on the output, plus a registered output stage.
- Two selection modes: round-robin arbitration, or fixed software select.
- Used in front of the UART TX path so several producers can share one transmitter.

---
 rtl/stream_mux_pkg.sv | 13 +
 rtl/stream_mux_rr_arbiter.sv | 43 ++++
 rtl/stream_mux_rr.sv | 112 +++++++++++
 tb/tb_stream_mux_rr.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

    // Selection mode encoding for the mode input
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Channel index after idx, wrapping from n-1 back to 0
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// searching upward from ptr, wrapping modulo N_CH.
module rr_arbiter #(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    // Channel index visited at each search offset, and whether it requests
    logic [SEL_W-1:0] cand_idx [N_CH];
    logic [N_CH-1:0]  cand_req;

    // ptr is always below N_CH, so ptr+offset needs at most one wrap correction
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
        logic [SEL_W:0] sum;
        assign sum          = {1'b0, ptr} + (SEL_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (SEL_W+1)'(N_CH)) ? SEL_W'(sum - (SEL_W+1)'(N_CH))
                                                         : SEL_W'(sum);
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    // Pick the lowest search offset with a request; walking downward lets it win last
    always_comb begin
        gnt_any    = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx[k];
            end
        end
        if (gnt_any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 streaming multiplexer with valid/ready on every port, a registered
// output stage, and either round-robin or fixed software channel selection.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic [N_CH-1:0]        in_ready,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_sel,
    input  logic                   out_ready
);

    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [SEL_W-1:0]  out_sel_reg;
    logic [SEL_W-1:0]  rr_ptr_reg;

    logic [N_CH-1:0]   arb_onehot;
    logic [SEL_W-1:0]  arb_idx;
    logic              arb_any;

    logic [N_CH-1:0]   fixed_onehot;

    logic              load_en;
    logic [N_CH-1:0]   gnt_onehot;
    logic [SEL_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic [DATA_W-1:0] gnt_data;
    logic              in_xfer;
    logic [SEL_W-1:0]  rr_ptr_next;

    // The output register can accept a beat when empty or being drained this cycle
    assign load_en = !out_valid_reg || out_ready;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req        (in_valid),
        .ptr        (rr_ptr_reg),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .gnt_any    (arb_any)
    );

    // Fixed select only matches in-range channels, so an out-of-range sel grants nothing
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_fixed
        assign fixed_onehot[gi] = (sel == SEL_W'(gi)) && in_valid[gi];
    end

    // Choose the grant source by mode and gate it into the per-channel ready
    always_comb begin
        if (mode == MODE_FIXED) begin
            gnt_onehot = fixed_onehot;
            gnt_idx    = sel;
            gnt_any    = |fixed_onehot;
        end else begin
            gnt_onehot = arb_onehot;
            gnt_idx    = arb_idx;
            gnt_any    = arb_any;
        end
        in_ready = (rst || !load_en) ? '0 : gnt_onehot;
        in_xfer  = !rst && load_en && gnt_any;
    end

    // AND-OR data select keyed on the one-hot grant; never reads past the bus
    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt_onehot[k]) begin
                gnt_data = gnt_data | in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign rr_ptr_next = SEL_W'(wrap_inc(32'(gnt_idx), N_CH));

    // Output register and round-robin pointer; refill takes priority over drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            rr_ptr_reg    <= '0;
        end else begin
            if (in_xfer) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= gnt_data;
                out_sel_reg   <= gnt_idx;
                if (mode == MODE_RR) begin
                    rr_ptr_reg <= rr_ptr_next;
                end
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: directed stimulus pushes the expected
// beats, a monitor pops and compares on every output transfer.
module tb_stream_mux_rr;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    // Second instance with a non-power-of-two channel count so sel can be out of range
    logic [4:0]  b_in_valid;
    logic [39:0] b_in_data;
    logic [4:0]  b_in_ready;
    logic        b_mode;
    logic [2:0]  b_sel;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic [2:0]  b_out_sel;
    logic        b_out_ready;

    int tests = 0;
    int fails = 0;
    beat_t sb[$];

    stream_mux_rr #(.N_CH(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    stream_mux_rr #(.N_CH(5), .DATA_W(8)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .mode      (b_mode),
        .sel       (b_sel),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
        .out_ready (b_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push(input int s, input int d);
        beat_t b;
        b.sel  = s[1:0];
        b.data = d[7:0];
        sb.push_back(b);
    endtask

    task automatic set_data(input int ch, input int v);
        in_data[ch*8 +: 8] = v[7:0];
    endtask

    // Monitor: every output transfer must match the oldest expected beat
    always @(negedge clk) begin
        beat_t e;
        if (!rst && out_valid && out_ready) begin
            $display("[TB] beat sel=%0d data=%02h", out_sel, out_data);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got sel %0d data %02h, required no beat", out_sel, out_data);
            end else begin
                e = sb.pop_front();
                chk("beat_sel", 32'(out_sel), 32'(e.sel));
                chk("beat_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 4'hF; in_data = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        b_in_valid = '0; b_in_data = '0; b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready_forced", 32'(in_ready), 32'h0);
        step();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'h0);
        step();

        // Load ch2 beat 0x5A and hold it, then reset mid-traffic
        rst = 1'b0; in_valid = 4'b0100; set_data(2, 8'h5A); out_ready = 1'b0;
        @(negedge clk);
        chk("load_in_ready", 32'(in_ready), 32'b0100);
        step();
        in_valid = 4'b0000;
        @(negedge clk);
        chk("held_out_valid", 32'(out_valid), 32'h1);
        chk("held_out_data", 32'(out_data), 32'h5A);
        chk("held_out_sel", 32'(out_sel), 32'h2);
        step();
        rst = 1'b1; in_valid = 4'hF;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        step();

        // Release reset straight into round-robin fairness
        rst = 1'b0; out_ready = 1'b1; in_valid = 4'hF;
        for (int c = 0; c < 4; c++) set_data(c, 8'h10 + c);
        @(negedge clk);
        chk("post_rst_out_valid", 32'(out_valid), 32'h0);
        chk("post_rst_out_data", 32'(out_data), 32'h0);
        chk("post_rst_out_sel", 32'(out_sel), 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk("rr_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
            if (i > 0) begin
                chk("rr_no_bubble", 32'(out_valid), 32'h1);
                chk("rr_out_sel", 32'(out_sel), 32'((i - 1) % 4));
            end
            push(i % 4, 8'h10 + (i % 4));
            step();
        end

        // Move the pointer to 2 with a lone ch1 request
        in_valid = 4'b0010; set_data(1, 8'h20);
        @(negedge clk);
        chk("ptr_set_in_ready", 32'(in_ready), 32'b0010);
        push(1, 8'h20);
        step();

        // Sparse requests from ch3 and ch1 starting at pointer 2
        in_valid = 4'b1010; set_data(1, 8'h21); set_data(3, 8'h23);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sparse_in_ready", 32'(in_ready), (i == 1) ? 32'b0010 : 32'b1000);
            push((i == 1) ? 1 : 3, (i == 1) ? 8'h21 : 8'h23);
            step();
        end
        in_valid = 4'b0000;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'h0);
        step();

        // Backpressure: beat 0xA5 held for 5 stalled cycles
        out_ready = 1'b0; in_valid = 4'b0001; set_data(0, 8'hA5);
        @(negedge clk);
        chk("bp_load_in_ready", 32'(in_ready), 32'b0001);
        push(0, 8'hA5);
        step();
        set_data(0, 8'hA6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_out_data", 32'(out_data), 32'hA5);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'b0001);
        push(0, 8'hA6);
        step();
        in_valid = 4'b0000;
        @(negedge clk);
        chk("bp_refill_valid", 32'(out_valid), 32'h1);
        chk("bp_refill_data", 32'(out_data), 32'hA6);
        step();

        // Fixed mode, sel=2, all channels requesting
        mode = 1'b1; sel = 2'd2; in_valid = 4'hF;
        for (int c = 0; c < 4; c++) set_data(c, 8'h30 + c);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fixed_in_ready", 32'(in_ready), 32'b0100);
            push(2, 8'h32);
            step();
        end

        // Back to round-robin: pointer was frozen at 1 during fixed mode
        mode = 1'b0;
        @(negedge clk);
        chk("mode_back_in_ready", 32'(in_ready), 32'b0010);
        push(1, 8'h31);
        step();
        in_valid = 4'b0000;
        step();

        // Out-of-range sel on the 5-channel instance
        b_mode = 1'b1; b_sel = 3'd3; b_in_valid = 5'h1F; b_in_data[3*8 +: 8] = 8'h43; b_out_ready = 1'b0;
        @(negedge clk);
        chk("oor_load_in_ready", 32'(b_in_ready), 32'b01000);
        step();
        b_sel = 3'd5;
        @(negedge clk);
        chk("oor_held_valid", 32'(b_out_valid), 32'h1);
        chk("oor_held_data", 32'(b_out_data), 32'h43);
        chk("oor_held_sel", 32'(b_out_sel), 32'h3);
        chk("oor_in_ready_stall", 32'(b_in_ready), 32'h0);
        step();
        b_out_ready = 1'b1;
        @(negedge clk);
        chk("oor_in_ready_drain", 32'(b_in_ready), 32'h0);
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("oor_drained_valid", 32'(b_out_valid), 32'h0);
            chk("oor_idle_in_ready", 32'(b_in_ready), 32'h0);
            step();
        end
        b_in_valid = '0;

        // Single-channel full throughput on ch1
        in_valid = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            set_data(1, i);
            @(negedge clk);
            chk("stream_in_ready", 32'(in_ready), 32'b0010);
            if (i > 0) begin
                chk("stream_out_valid", 32'(out_valid), 32'h1);
                chk("stream_out_data", 32'(out_data), 32'(i - 1));
            end
            push(1, i);
            step();
        end
        in_valid = 4'b0000;
        @(negedge clk);
        chk("stream_last_data", 32'(out_data), 32'h0F);

        // Let the scoreboard empty within a bounded number of cycles
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
